ecc_encode_pipe: RTL and testbench
==================================

ECC_ENCODE_PIPE -- requirements
Module: ecc_encode_pipe

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous, active-high reset.
REQ-002 SHALL have in_valid  in  1  input word valid; in_ready  out  1  input word accepted when in_valid & in_ready.
REQ-003 SHALL have in_data  in  32  data word; bit i is data bit i of the downstream corrector's data input.
REQ-004 SHALL have out_valid  out  1  codeword valid; out_ready  in  1  downstream accept.
REQ-005 SHALL have out_data  out  32  data word as delivered; out_chk  out  8  check bits; bit k drives the corrector's check input k.
REQ-006 SHALL have word_cnt  out  16  count of delivered codewords.
REQ-007 SHALL have inj_en  in  1  arm error injection; inj_bit  in  6  codeword bit to flip; out_inj  out  1  delivered word was corrupted.

Function
REQ-008 SHALL compute chk[k] as XOR of data bits: k0 {0,4,8,12,16-23}; k1 {1,5,9,13,24-31}; k2 {2,6,10,14,16-19,24-27}; k3 {3,7,11,15,20-23,28-31}; k4 {16,20,24,28,0-7}; k5 {17,21,25,29,8-15}; k6 {18,22,26,30,0-3,8-11}; k7 {19,23,27,31,4-7,12-15}.
REQ-009 SHALL be a 2-stage pipeline: stage 1 registers data and the 4-bit group XORs; stage 2 registers data and final chk; latency 2 cycles accept-to-out_valid when unstalled.
REQ-010 SHALL advance stage 2 when ~out_valid | out_ready; stage 1 when stage 1 empty or stage 2 advances; in_ready = ~s1_valid | s2_advance (combinational, no dependence on in_valid).
REQ-011 SHALL sustain one word per cycle with out_ready held high.
REQ-012 SHALL hold out_data, out_chk, out_inj stable while out_valid & ~out_ready; no word dropped or duplicated under any stall pattern.
REQ-013 SHALL increment word_cnt by 1 on each out_valid & out_ready; wraps 0xFFFF -> 0x0000.
REQ-014 SHALL keep words in acceptance order.

Reset
REQ-015 SHALL on rst clear both stage valids, out_valid=0, out_data=0, out_chk=0, out_inj=0, word_cnt=0, injection disarmed; in_ready=1 the cycle after rst deasserts.
REQ-016 SHALL discard in-flight words when rst asserts mid-stream; rst dominates simultaneous handshakes.

Configuration
REQ-017 With ERR_INJECT_EN defined: inj_en=1 with inj_bit<=39 arms a one-shot (latching inj_bit); the next accepted word (same cycle allowed) is tagged; at stage 2 bit inj_bit flips (0-31 data bit, 32-39 chk bit inj_bit-32) and out_inj=1; arm clears on use; inj_bit>39 ignored; re-arm while armed overwrites inj_bit.
REQ-018 Without ERR_INJECT_EN: inj_en/inj_bit ports present but ignored, out_inj constant 0, no injection logic.

Structure
REQ-019 SHALL use package ecc_pkg holding DATA_W=32, CHK_W=8, CW_W=40, and the eight 32-bit check-group masks of REQ-008.
REQ-020 SHALL instantiate one sub-module ecc_parity_gen (combinational, 32-bit data -> 8 chk bits from package masks), reusable by the syndrome path.

Verification
REQ-021 rst, then in_data=0x00000000 -> 2 cycles later out_chk=0x00, word_cnt=1 after handshake.
REQ-022 in_data=0x00000001 -> out_chk=0x51; in_data=0x00010000 -> out_chk=0x15; in_data=0xFFFFFFFF -> out_chk=0x00.
REQ-023 100 back-to-back words, out_ready=1 -> one output per cycle, order preserved, word_cnt=100; then random out_ready toggling -> no loss/duplication, stalled outputs stable.
REQ-024 ERR_INJECT_EN: arm inj_bit=5, send 0x00000000 -> out_data=0x00000020, out_chk=0x00, out_inj=1; next word uncorrupted; inj_bit=35 -> out_chk=0x08; inj_bit=45 -> no corruption.
REQ-025 rst with both stages full and out_ready=0 -> next cycle out_valid=0, word_cnt=0; word_cnt preset path via 65536 deliveries wraps to 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared widths, check-group masks and the codeword payload for the ECC encode/decode path.
package ecc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CHK_W  = 8;
  localparam int unsigned CW_W   = 40;
  localparam int unsigned GRP_N  = DATA_W / 4;
  localparam int unsigned GRP_W  = CHK_W * GRP_N;
  localparam int unsigned INJ_W  = 6;

  // Entry k selects the data bits that feed check bit k
  localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_MASK = {
    32'h8888_F0F0, 32'h4444_0F0F, 32'h2222_FF00, 32'h1111_00FF,
    32'hF0F0_8888, 32'h0F0F_4444, 32'hFF00_2222, 32'h00FF_1111
  };

  // Codeword bit i: 0..31 are data bits, 32..39 are check bits 0..7
  typedef struct packed {
    logic [CHK_W-1:0]  chk;
    logic [DATA_W-1:0] data;
  } cw_t;

  // Fold the per-nibble partial parities of each check bit into the final check bit
  function automatic logic [CHK_W-1:0] grp_fold(input logic [GRP_W-1:0] grp);
    logic [CHK_W-1:0] chk;
    chk = '0;
    for (int k = 0; k < int'(CHK_W); k++) begin
      chk[k] = ^grp[k*GRP_N +: GRP_N];
    end
    return chk;
  endfunction

endpackage

// File: rtl/ecc_parity_gen.sv
// Combinational check-bit generator: per-nibble partial parities plus the folded check bits.
module ecc_parity_gen
  import ecc_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [GRP_W-1:0]  grp_o,
  output logic [CHK_W-1:0]  chk_o
);

  for (genvar k = 0; k < CHK_W; k++) begin : g_chk
    for (genvar n = 0; n < GRP_N; n++) begin : g_grp
      assign grp_o[k*GRP_N+n] = ^(data_i[4*n +: 4] & CHK_MASK[k][4*n +: 4]);
    end
  end

  assign chk_o = grp_fold(grp_o);

endmodule

// File: rtl/ecc_encode_pipe.sv
// Two-stage ECC encoder with valid/ready flow control and a delivered-word counter.
// Defining ERR_INJECT_EN adds one-shot single-bit error injection on the codeword.
module ecc_encode_pipe
  import ecc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_chk,
  output logic [15:0]       word_cnt,
  input  logic              inj_en,
  input  logic [INJ_W-1:0]  inj_bit,
  output logic              out_inj
);

  localparam int unsigned CNT_W = 16;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [GRP_W-1:0]  s1_grp_q, s1_grp_d;
  logic              s2_valid_q, s2_valid_d;
  cw_t               s2_cw_q, s2_cw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s1_adv, s2_adv;
  logic [GRP_W-1:0]  grp_c;
  logic [CHK_W-1:0]  chk_c;
  logic [CW_W-1:0]   flip_c;

  ecc_parity_gen u_parity_gen (
    .data_i (in_data),
    .grp_o  (grp_c),
    .chk_o  (chk_c)
  );

  // Only the partial parities are registered; the folded bits serve the syndrome path
  logic unused_chk;
  assign unused_chk = ^chk_c;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_grp_d   = s1_grp_q;
    s2_valid_d = s2_valid_q;
    s2_cw_d    = s2_cw_q;
    cnt_d      = cnt_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_grp_d  = grp_c;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_cw_d = cw_t'({grp_fold(s1_grp_q), s1_data_q} ^ flip_c);
      end
    end
    if (s2_valid_q && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_grp_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_cw_q    <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_grp_q   <= s1_grp_d;
      s2_valid_q <= s2_valid_d;
      s2_cw_q    <= s2_cw_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_cw_q.data;
  assign out_chk   = s2_cw_q.chk;
  assign word_cnt  = cnt_q;

`ifdef ERR_INJECT_EN
  logic             accept, arm_now, arm_eff;
  logic             arm_q, arm_d;
  logic [INJ_W-1:0] arm_bit_q, arm_bit_d, bit_eff;
  logic             s1_inj_q, s1_inj_d;
  logic [INJ_W-1:0] s1_bit_q, s1_bit_d;
  logic             s2_inj_q, s2_inj_d;

  assign accept  = in_valid & s1_adv;
  assign arm_now = inj_en & (inj_bit <= INJ_W'(CW_W - 1));
  // A request in the accept cycle applies to that very word and overrides a pending bit
  assign arm_eff = arm_q | arm_now;
  assign bit_eff = arm_now ? inj_bit : arm_bit_q;

  always_comb begin
    arm_d     = arm_eff;
    arm_bit_d = bit_eff;
    s1_inj_d  = s1_inj_q;
    s1_bit_d  = s1_bit_q;
    s2_inj_d  = s2_inj_q;
    if (s1_adv) begin
      s1_inj_d = accept & arm_eff;
      s1_bit_d = bit_eff;
      if (accept) begin
        arm_d = 1'b0;
      end
    end
    if (s2_adv) begin
      s2_inj_d = s1_valid_q & s1_inj_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q     <= 1'b0;
      arm_bit_q <= '0;
      s1_inj_q  <= 1'b0;
      s1_bit_q  <= '0;
      s2_inj_q  <= 1'b0;
    end else begin
      arm_q     <= arm_d;
      arm_bit_q <= arm_bit_d;
      s1_inj_q  <= s1_inj_d;
      s1_bit_q  <= s1_bit_d;
      s2_inj_q  <= s2_inj_d;
    end
  end

  assign flip_c  = s1_inj_q ? (CW_W'(1) << s1_bit_q) : '0;
  assign out_inj = s2_inj_q;
`else
  logic unused_inj;
  assign unused_inj = ^{inj_en, inj_bit};
  assign flip_c     = '0;
  assign out_inj    = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_encode_pipe.sv
// Directed and streaming bench for ecc_encode_pipe; injection vectors follow ERR_INJECT_EN.
module tb_ecc_encode_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, inj_en, out_inj;
  logic [31:0] in_data, out_data;
  logic [7:0]  out_chk;
  logic [15:0] word_cnt;
  logic [5:0]  inj_bit;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  bit          stalled;
  logic [31:0] stall_data;
  logic [7:0]  stall_chk;
  int          n_in, n_out, first_out, last_out, step_idx;

  always #5 clk = ~clk;

  ecc_encode_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chk   (out_chk),
    .word_cnt  (word_cnt),
    .inj_en    (inj_en),
    .inj_bit   (inj_bit),
    .out_inj   (out_inj)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Column view of the check matrix: which check bits each data bit feeds
  function automatic logic [7:0] ref_chk(input logic [31:0] d);
    logic [7:0] c;
    int p;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) begin
        p = i % 4;
        if (i < 16) begin
          c[p] ^= 1'b1;
          c[(i < 8) ? 4 : 5] ^= 1'b1;
          c[((i / 4) % 2 == 0) ? 6 : 7] ^= 1'b1;
        end else begin
          c[4 + p] ^= 1'b1;
          c[(i < 24) ? 0 : 1] ^= 1'b1;
          c[((i / 4) % 2 == 0) ? 2 : 3] ^= 1'b1;
        end
      end
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; inj_en = 1'b0; inj_bit = '0;
    tick();
    tick();
    rst = 1'b0;
    stalled = 1'b0;
    exp_q.delete();
  endtask

  // One streaming cycle: drive, sample before the edge, score the handshakes
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy);
    logic [31:0] want;
    in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    if (stalled) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", out_data, stall_data);
      check("stall_chk", 32'(out_chk), 32'(stall_chk));
    end
    stalled    = out_valid & ~out_ready;
    stall_data = out_data;
    stall_chk  = out_chk;
    if (in_valid && in_ready) begin
      exp_q.push_back(d);
      n_in++;
    end
    if (out_valid && out_ready) begin
      check("out_has_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("stream_data", out_data, want);
        check("stream_chk", 32'(out_chk), 32'(ref_chk(want)));
        n_out++;
        if (first_out < 0) first_out = step_idx;
        last_out = step_idx;
      end
    end
    step_idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input logic [31:0] d, input logic ie, input logic [5:0] ib,
                          input logic [31:0] exp_data, input logic [7:0] exp_chk,
                          input logic exp_inj, input logic [15:0] exp_cnt);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1; inj_en = ie; inj_bit = ib;
    #1;
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; inj_en = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_chk"}, 32'(out_chk), 32'(exp_chk));
    check({tag, "_inj"}, 32'(out_inj), 32'(exp_inj));
    tick();
    check({tag, "_cnt"}, 32'(word_cnt), 32'(exp_cnt));
  endtask

  task automatic arm(input logic [5:0] b);
    inj_en = 1'b1; inj_bit = b; in_valid = 1'b0;
    tick();
    inj_en = 1'b0;
  endtask

  initial begin
    int  hs, hs_next;
    bit  seen_max;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; inj_en = 1'b0; inj_bit = '0;
    stalled = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_chk", 32'(out_chk), 32'd0);
    check("rst_out_inj", 32'(out_inj), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    send_one("zero",  32'h0000_0000, 1'b0, 6'd0, 32'h0000_0000, 8'h00, 1'b0, 16'd1);
    send_one("bit0",  32'h0000_0001, 1'b0, 6'd0, 32'h0000_0001, 8'h51, 1'b0, 16'd2);
    send_one("bit16", 32'h0001_0000, 1'b0, 6'd0, 32'h0001_0000, 8'h15, 1'b0, 16'd3);
    send_one("ones",  32'hFFFF_FFFF, 1'b0, 6'd0, 32'hFFFF_FFFF, 8'h00, 1'b0, 16'd4);
    send_one("nib1",  32'h0000_00F0, 1'b0, 6'd0, 32'h0000_00F0, 8'h0F, 1'b0, 16'd5);
    send_one("bit28", 32'h1000_0000, 1'b0, 6'd0, 32'h1000_0000, 8'h1A, 1'b0, 16'd6);

`ifdef ERR_INJECT_EN
    arm(6'd5);
    send_one("inj5",   32'h0, 1'b0, 6'd0,  32'h0000_0020, 8'h00, 1'b1, 16'd7);
    send_one("after",  32'h0, 1'b0, 6'd0,  32'h0000_0000, 8'h00, 1'b0, 16'd8);
    send_one("inj35",  32'h0, 1'b1, 6'd35, 32'h0000_0000, 8'h08, 1'b1, 16'd9);
    send_one("inj45",  32'h0, 1'b1, 6'd45, 32'h0000_0000, 8'h00, 1'b0, 16'd10);
    arm(6'd3);
    arm(6'd33);
    send_one("rearm",  32'h0, 1'b0, 6'd0,  32'h0000_0000, 8'h02, 1'b1, 16'd11);
`else
    arm(6'd5);
    send_one("noinj5",  32'h0, 1'b0, 6'd0,  32'h0000_0000, 8'h00, 1'b0, 16'd7);
    send_one("noinj35", 32'h0, 1'b1, 6'd35, 32'h0000_0000, 8'h00, 1'b0, 16'd8);
`endif

    // Fill both stages under backpressure, then reset with handshakes pending
    in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b0;
    tick();
    in_data = 32'h9ABC_DEF0;
    tick();
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_out_data", out_data, 32'h1234_5678);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_word_cnt", 32'(word_cnt), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_out_chk", 32'(out_chk), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    tick();
    check("midrst_discard", 32'(out_valid), 32'd0);

    // Back-to-back stream at full rate
    do_reset();
    n_in = 0; n_out = 0; first_out = -1; last_out = -1; step_idx = 0;
    for (int i = 0; i < 100; i++) step(1'b1, (32'(i) * 32'h9E37_79B1) ^ 32'(i), 1'b1);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(1'b0, 32'h0, 1'b1);
    check("b2b_accepted", 32'(n_in), 32'd100);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_delivered", 32'(n_out), 32'd100);
    check("b2b_first", 32'(first_out), 32'd2);
    check("b2b_rate", 32'(last_out - first_out + 1), 32'd100);
    check("b2b_word_cnt", 32'(word_cnt), 32'd100);

    // Random valid/ready pattern
    n_in = 0; n_out = 0;
    for (int c = 0; c < 2000 && n_in < 60; c++) begin
      step(($urandom_range(0, 3) != 0) && (n_in < 60), $urandom, $urandom_range(0, 1) != 0);
    end
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) step(1'b0, 32'h0, $urandom_range(0, 2) != 0);
    check("rnd_accepted", 32'(n_in), 32'd60);
    check("rnd_drained", 32'(exp_q.size()), 32'd0);
    check("rnd_delivered", 32'(n_out), 32'd60);
    check("rnd_word_cnt", 32'(word_cnt), 32'd160);

    // Counter wrap after 65536 deliveries
    do_reset();
    in_valid = 1'b1; in_data = 32'h0; out_ready = 1'b1;
    hs = 0; seen_max = 1'b0;
    for (int c = 0; c < 70000 && hs < 65536; c++) begin
      if (hs == 65535 && !seen_max) begin
        check("cnt_max", 32'(word_cnt), 32'h0000_FFFF);
        seen_max = 1'b1;
      end
      hs_next = hs + (out_valid ? 1 : 0);
      tick();
      hs = hs_next;
    end
    in_valid = 1'b0;
    check("wrap_handshakes", 32'(hs), 32'd65536);
    check("wrap_seen_max", 32'(seen_max), 32'd1);
    check("wrap_word_cnt", 32'(word_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
